// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: access-size codes, FSM states, size helper.
package dmem_pkg;

    // Access size codes carried on req_size.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        INIT,
        IDLE
    } state_e;

    // Number of bytes touched by an access of the given size code.
    function automatic int unsigned bytes_of(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory: store byte-merge and load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter  int unsigned DATA_W = 64,
    localparam int unsigned LB     = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] word,      // current array word
    input  logic [DATA_W-1:0] wdata,     // store data, LSB-aligned
    input  logic [LB-1:0]     lane,      // byte offset within the word
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] merged,    // word with the store lanes replaced
    output logic [DATA_W-1:0] rdata      // extracted and extended load value
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    int unsigned       nbits;
    int unsigned       shamt;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] sbit_vec;

    // Build an access mask of the access width, then merge for stores and extract for loads.
    always_comb begin
        nbits = bytes_of(size) * 8;
        shamt = 32'(lane) * 8;
        if (nbits >= DATA_W) begin
            mask = '1;
        end else begin
            mask = (ONE << nbits) - ONE;
        end
        merged   = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
        shifted  = word >> shamt;
        // Bit 0 of sbit_vec is the top bit of the extracted field.
        sbit_vec = shifted >> (nbits - 1);
        rdata    = shifted & mask;
        if (sign_ext && sbit_vec[0] && (nbits < DATA_W)) begin
            rdata = rdata | ~mask;
        end
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sized loads/stores, init sweep and registered response.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       DEPTH      = 1024,
    parameter int unsigned       ADDR_W     = 64,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              init_done
);

    localparam int unsigned LB    = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;
    logic              resp_valid_q, resp_error_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic [LB-1:0]     lane;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] load_val;
    int unsigned       nbytes;
    logic              err;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Address decode and error classification; the full address is range-checked.
    always_comb begin
        accept   = req_valid && (state_q == IDLE);
        word_idx = req_addr >> LB;
        idx      = word_idx[IDX_W-1:0];
        lane     = req_addr[LB-1:0];
        rd_word  = mem[idx];
        nbytes   = bytes_of(req_size);
        err      = ((req_addr & ADDR_W'(nbytes - 1)) != '0)
                || (nbytes > DATA_W / 8)
                || (word_idx >= ADDR_W'(DEPTH));
    end

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .word     (rd_word),
        .wdata    (req_wdata),
        .lane     (lane),
        .size     (req_size),
        .sign_ext (req_signed),
        .merged   (merged),
        .rdata    (load_val)
    );

    // Next-state, init sweep and array write-port selection.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        req_ready   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = idx;
        mem_wdata   = merged;
        unique case (state_q)
            INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = INIT_VALUE;
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d     = IDLE;
                    init_cnt_d  = '0;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
                mem_we    = accept && req_write && !err;
            end
            default: state_d = INIT;
        endcase
    end

    // State, init counter and response registers; reset drops any in-flight response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= accept;
            resp_error_q <= accept && err;
            resp_rdata_q <= (accept && !err && !req_write) ? load_val : '0;
        end
    end

    // Single array write port shared by the init sweep and stores.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign init_done  = init_done_q;

endmodule
